// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer.
// Holds the FSM state encoding, the init table entry layout, the power-up
// register table and the engine status codes.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    NEXT,
    DONE,
    FAIL,
    RT_ARM,
    RT_RUN
  } state_e;

  // One register write: 7-bit codec register address, 9-bit payload.
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

  localparam logic [3:0] ERR_TIMEOUT = 4'hE;
  localparam logic [3:0] ERR_PASS    = 4'hF;

  // Power-up table. Only the first NUM_REGS entries are walked; the spare
  // slots exist so the table can grow without touching the sequencer.
  localparam cfg_entry_t INIT_TABLE [16] = '{
    '{addr: 7'h0F, data: 9'h000},  // software reset
    '{addr: 7'h06, data: 9'h010},  // power down control: all on except outputs gate
    '{addr: 7'h04, data: 9'h012},  // analog audio path
    '{addr: 7'h05, data: 9'h000},  // digital audio path
    '{addr: 7'h07, data: 9'h04A},  // digital interface format
    '{addr: 7'h08, data: 9'h000},  // sample rate
    '{addr: 7'h09, data: 9'h001},  // interface active
    '{addr: 7'h00, data: 9'h017},  // left line in
    '{addr: 7'h01, data: 9'h017},  // right line in
    '{addr: 7'h02, data: 9'h079},  // left headphone volume
    '{addr: 7'h00, data: 9'h000},
    '{addr: 7'h00, data: 9'h000},
    '{addr: 7'h00, data: 9'h000},
    '{addr: 7'h00, data: 9'h000},
    '{addr: 7'h00, data: 9'h000},
    '{addr: 7'h00, data: 9'h000}
  };

  // Engine codes 1..5 are real I2C failures (NACKs etc.); anything else
  // other than PASS means the engine is still working.
  function automatic logic is_eng_err(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd5);
  endfunction

endpackage

// File: rtl/codec_cfg_seq_sync.sv
// cfg_sync2: 2-flop synchroniser for the engine status {done, error[3:0]}.
// Latency: 2 clk cycles. No backpressure (free-running).
// Ports: clk, rst (sync, active-high), d_i (async 5-bit in), q_o (synced out).
module cfg_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_i,
  output logic [4:0] q_o
);

  logic [4:0] meta_q;
  logic [4:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: walks the power-up register table onto the I2C write engine,
// retrying failed entries, then serves runtime register writes.
// Latency: engine status seen 2 cycles after it changes; ARM holds reset 2 cycles.
// Backpressure: wr_req is held by the requester until the one-cycle wr_ack.
// Ports: clk/rst; start, busy, init_done, init_fail, fail_index, fail_code;
//   wr_req/wr_reg/wr_data/wr_ack runtime path; i2c_* to/from the engine.
// Build option: CODEC_CFG_RUNTIME_WR_EN enables the runtime write path;
//   without it wr_req is ignored, wr_ack stays 0 and DONE is terminal.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS       = 10,
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 32768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  output logic       init_fail,
  output logic [3:0] fail_index,
  output logic [3:0] fail_code,
  input  logic       wr_req,
  input  logic [6:0] wr_reg,
  input  logic [8:0] wr_data,
  output logic       wr_ack,
  output logic       i2c_rst_n,
  output logic [6:0] i2c_address,
  output logic [6:0] i2c_register,
  output logic [8:0] i2c_data,
  output logic       i2c_rw,
  input  logic       i2c_done,
  input  logic [3:0] i2c_error
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    retry_q, retry_d;
  logic          arm_cnt_q, arm_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [6:0]    reg_q, reg_d;
  logic [8:0]    data_q, data_d;
  logic          rst_n_q, rst_n_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [3:0]    fidx_q, fidx_d;
  logic [3:0]    fcode_q, fcode_d;
  logic          ack_q, ack_d;

  logic [4:0]    eng_sync;
  logic          eng_done;
  logic [3:0]    eng_err;
  logic          txn_ok, txn_err, txn_tmo, retry_left;
  logic [3:0]    txn_code;

  cfg_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({i2c_done, i2c_error}),
    .q_o (eng_sync)
  );

  assign eng_done   = eng_sync[4];
  assign eng_err    = eng_sync[3:0];
  assign txn_ok     = eng_done && (eng_err == ERR_PASS);
  assign txn_err    = is_eng_err(eng_err);
  assign txn_tmo    = (tmo_q == TMO_LAST);
  // An engine error wins over a simultaneous timeout: it is the more specific code.
  assign txn_code   = txn_err ? eng_err : ERR_TIMEOUT;
  assign retry_left = (retry_q + 4'd1) < RETRY_LIM;

`ifndef CODEC_CFG_RUNTIME_WR_EN
  logic unused_wr;
  assign unused_wr = ^{wr_req, wr_reg, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      arm_cnt_q <= 1'b0;
      tmo_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      rst_n_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      fidx_q    <= '0;
      fcode_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      arm_cnt_q <= arm_cnt_d;
      tmo_q     <= tmo_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      fidx_q    <= fidx_d;
      fcode_q   <= fcode_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    arm_cnt_d = 1'b0;
    tmo_d     = tmo_q;
    reg_d     = reg_q;
    data_d    = data_q;
    done_d    = done_q;
    fail_d    = fail_q;
    fidx_d    = fidx_q;
    fcode_d   = fcode_q;
    ack_d     = 1'b0;

    unique case (state_q)
      IDLE, FAIL: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          tmo_d   = '0;
          reg_d   = INIT_TABLE[0].addr;
          data_d  = INIT_TABLE[0].data;
          fail_d  = 1'b0;
          state_d = ARM;
        end
      end
      ARM: begin
        // Two cycles of engine reset; arm_cnt_q is always 0 on entry.
        tmo_d     = '0;
        arm_cnt_d = ~arm_cnt_q;
        if (arm_cnt_q) state_d = RUN;
      end
      RUN: begin
        if (txn_ok) begin
          state_d = NEXT;
        end else if (txn_err || txn_tmo) begin
          if (retry_left) begin
            retry_d = retry_q + 4'd1;
            state_d = ARM;
          end else begin
            fidx_d  = idx_q;
            fcode_d = txn_code;
            fail_d  = 1'b1;
            state_d = FAIL;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          retry_d = '0;
          reg_d   = INIT_TABLE[idx_q + 4'd1].addr;
          data_d  = INIT_TABLE[idx_q + 4'd1].data;
          state_d = ARM;
        end
      end
`ifdef CODEC_CFG_RUNTIME_WR_EN
      DONE: begin
        // The cycle wr_ack is high the requester has not yet dropped wr_req.
        if (wr_req && !ack_q) begin
          reg_d   = wr_reg;
          data_d  = wr_data;
          retry_d = '0;
          state_d = RT_ARM;
        end
      end
      RT_ARM: begin
        tmo_d     = '0;
        arm_cnt_d = ~arm_cnt_q;
        if (arm_cnt_q) state_d = RT_RUN;
      end
      RT_RUN: begin
        if (txn_ok) begin
          ack_d   = 1'b1;
          state_d = DONE;
        end else if (txn_err || txn_tmo) begin
          if (retry_left) begin
            retry_d = retry_q + 4'd1;
            state_d = RT_ARM;
          end else begin
            ack_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  // Engine runs only while a transaction is live or once init has finished.
  always_comb begin
    rst_n_d = (state_d == RUN) || (state_d == NEXT) ||
              (state_d == DONE) || (state_d == RT_RUN);
  end

  assign busy = (state_q == ARM) || (state_q == RUN) || (state_q == NEXT) ||
                (state_q == RT_ARM) || (state_q == RT_RUN);

  assign init_done    = done_q;
  assign init_fail    = fail_q;
  assign fail_index   = fidx_q;
  assign fail_code    = fcode_q;
  assign wr_ack       = ack_q;
  assign i2c_rst_n    = rst_n_q;
  assign i2c_address  = DEV_ADDR;
  assign i2c_register = reg_q;
  assign i2c_data     = data_q;
  assign i2c_rw       = 1'b0;

endmodule
